// File: rtl/tick_period_meter_if.sv
// Measurement channel of tick_period_meter: one period/high-time result per transfer.
// A transfer completes on every clk edge where meas_valid & meas_ready; the producer keeps data stable until then.
interface tick_period_meter_if #(
  parameter int CNT_W = 24
);
  logic             meas_valid;
  logic             meas_ready;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_overrun;

  modport master (
    output meas_valid,
    output period,
    output high_time,
    output meas_overrun,
    input  meas_ready
  );

  modport slave (
    input  meas_valid,
    input  period,
    input  high_time,
    input  meas_overrun,
    output meas_ready
  );
endinterface

// File: rtl/tick_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk cycles,
// presenting one result per input period on a valid/ready channel.
module tick_period_meter #(
  parameter int               CNT_W   = 24,
  parameter logic [CNT_W-1:0] TIMEOUT = 24'd12500000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_in,
  tick_period_meter_if.master meas,
  output logic               stalled,
  output logic               stateDbg
);

  typedef enum logic {
    WAIT_EDGE = 1'b0,
    RUN       = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           stateNext;
  logic             sync1;
  logic             sync2;
  logic             hist;
  logic             rise;
  logic             capture;
  logic             timeout;
  logic             accept;
  logic [CNT_W-1:0] periodCnt;
  logic [CNT_W-1:0] highCnt;

  assign rise     = sync2 & ~hist;
  assign accept   = meas.meas_valid & meas.meas_ready;
  assign stateDbg = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= tick_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_EDGE;
    end else begin
      state <= stateNext;
    end
  end

  // A rise outranks the timeout, so a period of exactly TIMEOUT still measures.
  always_comb begin
    stateNext = state;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      WAIT_EDGE: begin
        if (rise) stateNext = RUN;
      end
      RUN: begin
        if (rise) begin
          capture = 1'b1;
        end else if (periodCnt == TIMEOUT) begin
          timeout   = 1'b1;
          stateNext = WAIT_EDGE;
        end
      end
      default: stateNext = WAIT_EDGE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      periodCnt <= '0;
      highCnt   <= '0;
    end else if (rise) begin
      periodCnt <= ONE;
      highCnt   <= ONE;
    end else if (state == RUN && !timeout) begin
      periodCnt <= periodCnt + ONE;
      highCnt   <= highCnt + {{(CNT_W-1){1'b0}}, sync2};
    end else begin
      periodCnt <= '0;
      highCnt   <= '0;
    end
  end

  // Overrun marks a result that replaced one the consumer never took.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meas.meas_valid   <= 1'b0;
      meas.meas_overrun <= 1'b0;
      meas.period       <= '0;
      meas.high_time    <= '0;
      stalled           <= 1'b0;
    end else begin
      if (capture) begin
        meas.period       <= periodCnt;
        meas.high_time    <= highCnt;
        meas.meas_valid   <= 1'b1;
        meas.meas_overrun <= meas.meas_valid & ~meas.meas_ready;
      end else if (accept) begin
        meas.meas_valid   <= 1'b0;
        meas.meas_overrun <= 1'b0;
      end
      if (capture) begin
        stalled <= 1'b0;
      end else if (timeout) begin
        stalled <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Directed bench for tick_period_meter: cycle model of edge timing/handshake plus
// a queue of hand-computed accepted measurements.
module tb_tick_period_meter;

  localparam int               CNT_W   = 24;
  localparam logic [CNT_W-1:0] TIMEOUT = 24'd100;
  localparam int               EW      = 2 * CNT_W + 1;

  logic clk;
  logic rst_n;
  logic tick_in;
  logic stalled;
  logic stateDbg;

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  tick_period_meter_if #(.CNT_W(CNT_W)) measIf ();

  tick_period_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_in (tick_in),
    .meas    (measIf),
    .stalled (stalled),
    .stateDbg(stateDbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: per-edge input samples; a rise is seen two edges after the sample
  // that first shows the input high.
  bit            tickSamp[$];
  bit            armed;
  int            lastRise;
  int            highAcc;
  bit            mValid;
  bit            mOver;
  bit            mStalled;
  int            mPer;
  int            mHi;

  function automatic bit sampAt(input int i);
    if (i < 0 || i >= tickSamp.size()) return 1'b0;
    return tickSamp[i];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickSamp.delete();
      armed    = 1'b0;
      lastRise = 0;
      highAcc  = 0;
      mValid   = 1'b0;
      mOver    = 1'b0;
      mStalled = 1'b0;
      mPer     = 0;
      mHi      = 0;
    end else begin
      int e;
      bit lvl;
      bit rs;
      bit acc;
      bit cap;
      int cP;
      int cH;
      tickSamp.push_back(tick_in);
      e   = tickSamp.size() - 1;
      lvl = sampAt(e - 2);
      rs  = lvl && !sampAt(e - 3);
      acc = mValid && measIf.meas_ready;
      cap = 1'b0;
      cP  = 0;
      cH  = 0;
      if (armed && rs) begin
        cap = 1'b1;
        cP  = e - lastRise;
        cH  = highAcc;
      end else if (armed && (e - lastRise) == int'(TIMEOUT)) begin
        armed    = 1'b0;
        mStalled = 1'b1;
      end
      if (rs) begin
        armed    = 1'b1;
        lastRise = e;
        highAcc  = 1;
      end else if (armed) begin
        highAcc += int'(lvl);
      end
      if (cap) begin
        mOver    = mValid && !acc;
        mValid   = 1'b1;
        mPer     = cP;
        mHi      = cH;
        mStalled = 1'b0;
      end else if (acc) begin
        mValid = 1'b0;
        mOver  = 1'b0;
      end
    end
  end

  // scoreboard: every cycle against the model, every transfer against exp_q
  always @(negedge clk) begin
    if (rst_n) begin
      chk("meas_valid",   64'(measIf.meas_valid),   64'(mValid));
      chk("meas_overrun", 64'(measIf.meas_overrun), 64'(mOver));
      chk("stalled",      64'(stalled),             64'(mStalled));
      chk("state",        64'(stateDbg),            64'(armed));
      chk("period",       64'(measIf.period),       64'(mPer));
      chk("high_time",    64'(measIf.high_time),    64'(mHi));
      if (measIf.meas_valid && measIf.meas_ready) begin
        if (exp_q.size() == 0) begin
          chk("accept_unexpected", 64'(1), 64'(0));
        end else begin
          logic [EW-1:0] ex;
          ex = exp_q.pop_front();
          chk("acc_period",  64'(measIf.period),       64'(ex[2*CNT_W-1:CNT_W]));
          chk("acc_high",    64'(measIf.high_time),    64'(ex[CNT_W-1:0]));
          chk("acc_overrun", 64'(measIf.meas_overrun), 64'(ex[EW-1]));
        end
      end
    end
  end

  // driver tasks
  task automatic pushExp(input bit ov, input int p, input int h, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({ov, CNT_W'(p), CNT_W'(h)});
  endtask

  // rdyCyc: -1 ready held high, -2 held low, otherwise a one-cycle pulse at that cycle
  task automatic drivePeriod(input int p, input int h, input int rdyCyc);
    for (int c = 0; c < p; c++) begin
      @(posedge clk);
      #1;
      tick_in = (c < h);
      if (rdyCyc == -1)      measIf.meas_ready = 1'b1;
      else if (rdyCyc == -2) measIf.meas_ready = 1'b0;
      else                   measIf.meas_ready = (c == rdyCyc);
    end
  endtask

  task automatic checkAllZero(input string tag);
    chk({tag, "_valid"},   64'(measIf.meas_valid),   64'(0));
    chk({tag, "_overrun"}, 64'(measIf.meas_overrun), 64'(0));
    chk({tag, "_stalled"}, 64'(stalled),             64'(0));
    chk({tag, "_period"},  64'(measIf.period),       64'(0));
    chk({tag, "_high"},    64'(measIf.high_time),    64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    total++;
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    rst_n             = 1'b0;
    tick_in           = 1'b0;
    measIf.meas_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // steady P=16 H=8; the first rise only arms the meter
    pushExp(1'b0, 16, 8, 4);
    drivePeriod(16, 8, -1);
    chk("first_rise_no_valid", 64'(measIf.meas_valid), 64'(0));
    for (int i = 0; i < 3; i++) drivePeriod(16, 8, -1);

    // duty sweep at P=20; last period is captured but never taken
    pushExp(1'b0, 20, 1, 2);
    pushExp(1'b0, 20, 10, 2);
    pushExp(1'b0, 20, 19, 1);
    drivePeriod(20, 1, -1);
    drivePeriod(20, 1, -1);
    drivePeriod(20, 10, -1);
    drivePeriod(20, 10, -1);
    drivePeriod(20, 19, -1);
    drivePeriod(20, 19, -1);

    // two captures without ready, then a single-cycle accept
    pushExp(1'b1, 16, 8, 1);
    drivePeriod(16, 8, -2);
    chk("ovr_first_valid", 64'(measIf.meas_valid),   64'(1));
    chk("ovr_first_ovr",   64'(measIf.meas_overrun), 64'(0));
    chk("ovr_first_per",   64'(measIf.period),       64'(20));
    chk("ovr_first_high",  64'(measIf.high_time),    64'(19));
    drivePeriod(16, 8, 6);
    chk("ovr_after_valid", 64'(measIf.meas_valid),   64'(0));
    chk("ovr_after_ovr",   64'(measIf.meas_overrun), 64'(0));

    // capture coincident with acceptance
    pushExp(1'b0, 16, 8, 1);
    drivePeriod(12, 5, -2);
    drivePeriod(12, 5, 2);
    chk("coinc_valid", 64'(measIf.meas_valid),   64'(1));
    chk("coinc_per",   64'(measIf.period),       64'(12));
    chk("coinc_high",  64'(measIf.high_time),    64'(5));
    chk("coinc_ovr",   64'(measIf.meas_overrun), 64'(0));
    pushExp(1'b0, 12, 5, 2);
    drivePeriod(12, 5, -1);

    // stall, then resume
    drivePeriod(50, 0, -1);
    chk("stall_not_yet", 64'(stalled), 64'(0));
    drivePeriod(70, 0, -1);
    chk("stall_set", 64'(stalled), 64'(1));
    pushExp(1'b0, 16, 8, 2);
    drivePeriod(16, 8, -1);
    chk("resume_first_valid",   64'(measIf.meas_valid), 64'(0));
    chk("resume_first_stalled", 64'(stalled),           64'(1));
    drivePeriod(16, 8, -1);
    chk("resume_second_stalled", 64'(stalled), 64'(0));
    drivePeriod(16, 8, -1);

    // asynchronous reset while a result is pending
    drivePeriod(16, 8, -2);
    chk("pre_reset_valid", 64'(measIf.meas_valid), 64'(1));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_reset");
    chk("async_reset_state", 64'(stateDbg), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pushExp(1'b0, 16, 8, 2);
    drivePeriod(16, 8, -1);
    chk("post_reset_first_valid", 64'(measIf.meas_valid), 64'(0));
    drivePeriod(16, 8, -1);
    drivePeriod(16, 8, -1);
    drivePeriod(8, 0, -1);

    chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
